// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared ID/EX control word layout, bubble constant and issue states
package cpu_ctrl_pkg;
   localparam int CTRL_W = 42;
   typedef struct packed {
      logic [3:0] af;
      logic       i;
      logic       alu_mux_sel;
      logic [2:0] shift_type;
      logic [4:0] cad;
      logic       gp_we;
      logic [2:0] gp_mux_sel;
      logic [3:0] bf;
      logic [1:0] pc_mux_select;
      logic       spr_mux_sel;
      logic       mem_wren;
      logic       mem_rren;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } ctrl_word_t;
   localparam ctrl_word_t CTRL_BUBBLE = '0;
   typedef enum logic [1:0] {RUN, LDUSE, MWAIT} issue_state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID word that reads the destination of a load sitting in EX
module load_use_detect
   import cpu_ctrl_pkg::*;
(
   input  logic [CTRL_W-1:0] ex_word,
   input  logic              ex_valid,
   input  logic [CTRL_W-1:0] id_word,
   input  logic              id_valid,
   output logic              haz
);
   ctrl_word_t ex, id;
   logic unused_bits;
   assign ex = ex_word;
   assign id = id_word;
   assign unused_bits = ^{ex_word, id_word};
   // rs and rt are both compared even when the opcode reads only one of them
   assign haz = ex_valid & ex.mem_rren & ex.gp_we & (ex.cad != '0) & id_valid
              & ((ex.cad == id.rs) | (ex.cad == id.rt));
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: ID/EX pipeline register with load-use bubble, memory hold, flush kill and perf counters
module issue_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int W     = CTRL_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     id_word,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic             mem_busy,
   input  logic             flush,
   output logic [W-1:0]     ex_word,
   output logic             ex_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [7:0]       flush_cnt
);
   logic         haz;
   logic [W-1:0] word_nxt;
   logic         valid_nxt;
   issue_state_t state, state_nxt;

   load_use_detect u_lud (
      .ex_word (ex_word),
      .ex_valid(ex_valid),
      .id_word (id_word),
      .id_valid(id_valid),
      .haz     (haz)
   );

   assign id_ready = !rst & !flush & !mem_busy & !haz;

   always_comb begin
      word_nxt  = flush ? W'(CTRL_BUBBLE) : mem_busy ? ex_word : haz ? W'(CTRL_BUBBLE) : id_valid ? id_word : W'(CTRL_BUBBLE);
      valid_nxt = flush ? 1'b0 : mem_busy ? ex_valid : !haz & id_valid;
      state_nxt = flush ? RUN : mem_busy ? MWAIT : haz ? LDUSE : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_word   <= '0;
         ex_valid  <= 1'b0;
         state     <= RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         ex_word  <= word_nxt;
         ex_valid <= valid_nxt;
         state    <= state_nxt;
         if (id_valid && !id_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 8'd1;
      end
   end

   // the inserted bubble cannot itself be a load, so a load-use stall never repeats
   assert property (@(posedge clk) disable iff (rst) (state == LDUSE) |=> (state != LDUSE));
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed vector table, corner sequences and randomized model comparison for issue_ctrl
module tb_issue_ctrl;
   import cpu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [41:0] id_word = '0;
   logic        id_valid = 1'b0;
   logic        id_ready;
   logic        mem_busy = 1'b0;
   logic        flush = 1'b0;
   logic [41:0] ex_word;
   logic        ex_valid;
   logic [15:0] stall_cnt;
   logic [7:0]  flush_cnt;

   issue_ctrl dut (
      .clk(clk), .rst(rst), .id_word(id_word), .id_valid(id_valid), .id_ready(id_ready),
      .mem_busy(mem_busy), .flush(flush), .ex_word(ex_word), .ex_valid(ex_valid),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r, v, mb, fl;
      logic [41:0] w;
      logic        exp_ready, exp_valid;
      logic [41:0] exp_word;
      int          exp_stall;
   } vec_t;

   int checks = 0;
   int errors = 0;
   logic got_ready;

   // reference: pipeline slot contents and counters evolved by the priority rules
   logic [41:0]  m_word = '0;
   logic         m_valid = 1'b0;
   logic         m_ready;
   int           m_stall = 0;
   int           m_flush = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [41:0] mk(input logic [4:0] cad, rs, rt, input logic ld, input logic [3:0] tag);
      ctrl_word_t c;
      c = '0;
      c.af = tag;
      c.bf = ~tag;
      c.cad = cad;
      c.rs = rs;
      c.rt = rt;
      c.rd = {1'b0, tag};
      c.gp_we = 1'b1;
      c.mem_rren = ld;
      return c;
   endfunction

   task automatic model_step(input logic r, v, input logic [41:0] w, input logic mb, fl);
      ctrl_word_t e, d;
      logic hz;
      e = m_word;
      d = w;
      hz = m_valid && e.mem_rren && e.gp_we && e.cad != 0 && v && (e.cad == d.rs || e.cad == d.rt);
      m_ready = !r && !fl && !mb && !hz;
      if (r) begin
         m_word = '0; m_valid = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (v && !m_ready) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
         if (fl) m_flush = (m_flush < 255) ? m_flush + 1 : 255;
         if (fl || (!mb && (hz || !v))) begin
            m_word = '0; m_valid = 0;
         end else if (!mb) begin
            m_word = w; m_valid = 1;
         end
      end
   endtask

   task automatic cycle(input logic r, v, input logic [41:0] w, input logic mb, fl);
      rst = r; id_valid = v; id_word = w; mem_busy = mb; flush = fl;
      #1;
      got_ready = id_ready;
      model_step(r, v, w, mb, fl);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mv(input logic r, v, mb, fl, input logic [41:0] w,
                               input logic er, ev, input logic [41:0] ew, input int es);
      vec_t t;
      t.r = r; t.v = v; t.mb = mb; t.fl = fl; t.w = w;
      t.exp_ready = er; t.exp_valid = ev; t.exp_word = ew; t.exp_stall = es;
      return t;
   endfunction

   initial begin
      vec_t tv[23];
      logic [41:0] a, b, c, d, l, u, n, l0, z, e, v5;
      logic [41:0] rw;
      logic rv, rr, rmb, rfl;
      a  = mk(0, 0, 0, 0, 1);
      b  = mk(0, 0, 0, 0, 2);
      c  = mk(0, 0, 0, 0, 3);
      d  = mk(0, 0, 0, 0, 4);
      l  = mk(5, 1, 2, 1, 5);
      u  = mk(7, 5, 3, 0, 6);
      n  = mk(8, 6, 6, 0, 7);
      l0 = mk(0, 1, 2, 1, 8);
      z  = mk(9, 0, 0, 0, 9);
      e  = mk(10, 1, 1, 0, 10);
      v5 = mk(11, 4, 5, 0, 11);
      tv[0]  = mv(1, 1, 0, 0, a,  0, 0, '0, 0);
      tv[1]  = mv(1, 1, 0, 0, a,  0, 0, '0, 0);
      tv[2]  = mv(0, 1, 0, 0, a,  1, 1, a,  0);
      tv[3]  = mv(0, 1, 0, 0, b,  1, 1, b,  0);
      tv[4]  = mv(0, 1, 0, 0, c,  1, 1, c,  0);
      tv[5]  = mv(0, 1, 0, 0, d,  1, 1, d,  0);
      tv[6]  = mv(0, 1, 0, 0, l,  1, 1, l,  0);
      tv[7]  = mv(0, 1, 0, 0, u,  0, 0, '0, 1);
      tv[8]  = mv(0, 1, 0, 0, u,  1, 1, u,  1);
      tv[9]  = mv(0, 1, 0, 0, l,  1, 1, l,  1);
      tv[10] = mv(0, 1, 0, 0, n,  1, 1, n,  1);
      tv[11] = mv(0, 1, 0, 0, l0, 1, 1, l0, 1);
      tv[12] = mv(0, 1, 0, 0, z,  1, 1, z,  1);
      tv[13] = mv(0, 1, 1, 0, e,  0, 1, z,  2);
      tv[14] = mv(0, 1, 1, 0, e,  0, 1, z,  3);
      tv[15] = mv(0, 1, 1, 0, e,  0, 1, z,  4);
      tv[16] = mv(0, 1, 0, 0, e,  1, 1, e,  4);
      tv[17] = mv(0, 1, 0, 0, l,  1, 1, l,  4);
      tv[18] = mv(0, 1, 1, 1, u,  0, 0, '0, 5);
      tv[19] = mv(0, 0, 0, 0, '0, 1, 0, '0, 5);
      tv[20] = mv(0, 1, 0, 0, l,  1, 1, l,  5);
      tv[21] = mv(0, 1, 0, 0, v5, 0, 0, '0, 6);
      tv[22] = mv(0, 1, 0, 0, v5, 1, 1, v5, 6);

      @(posedge clk);
      #1;
      for (int i = 0; i < 23; i++) begin
         cycle(tv[i].r, tv[i].v, tv[i].w, tv[i].mb, tv[i].fl);
         chk($sformatf("vec%0d id_ready", i), 64'(got_ready), 64'(tv[i].exp_ready));
         chk($sformatf("vec%0d ex_valid", i), 64'(ex_valid), 64'(tv[i].exp_valid));
         chk($sformatf("vec%0d ex_word", i), 64'(ex_word), 64'(tv[i].exp_word));
         chk($sformatf("vec%0d stall_cnt", i), 64'(stall_cnt), 64'(tv[i].exp_stall));
      end
      chk("flush_cnt after one flush", 64'(flush_cnt), 64'(1));
      chk("state after flush+haz+busy", 64'(dut.state), 64'(RUN));

      cycle(0, 1, l, 0, 0);
      cycle(0, 1, u, 0, 0);
      chk("state load-use", 64'(dut.state), 64'(LDUSE));
      cycle(0, 1, u, 0, 0);
      chk("state after bubble", 64'(dut.state), 64'(RUN));
      chk("dependent word issued", 64'(ex_word), 64'(u));
      cycle(0, 1, e, 1, 0);
      chk("state mem wait", 64'(dut.state), 64'(MWAIT));
      cycle(0, 1, e, 0, 0);
      chk("state wait exit", 64'(dut.state), 64'(RUN));

      repeat (300) cycle(0, 0, '0, 0, 1);
      chk("flush_cnt saturation", 64'(flush_cnt), 64'(255));

      cycle(0, 1, l, 0, 0);
      cycle(0, 1, e, 1, 0);
      cycle(1, 1, e, 1, 0);
      chk("reset mid-stall id_ready", 64'(got_ready), 64'(0));
      chk("reset mid-stall ex_valid", 64'(ex_valid), 64'(0));
      chk("reset mid-stall stall_cnt", 64'(stall_cnt), 64'(0));
      chk("reset mid-stall flush_cnt", 64'(flush_cnt), 64'(0));
      cycle(0, 1, u, 0, 0);
      chk("first accept after reset ready", 64'(got_ready), 64'(1));
      chk("first accept after reset word", 64'(ex_word), 64'(u));

      cycle(1, 0, '0, 0, 0);
      rw = '0;
      rv = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!(rv && !got_ready)) begin
            rv = ($urandom % 4) != 0;
            rw = mk(5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4), 1'($urandom), 4'($urandom));
            rw[16] = 1'($urandom % 8 == 0);
         end
         rr  = ($urandom % 60) == 0;
         rmb = ($urandom % 6) == 0;
         rfl = ($urandom % 8) == 0;
         cycle(rr, rv, rw, rmb, rfl);
         chk("rand id_ready", 64'(got_ready), 64'(m_ready));
         chk("rand ex_valid", 64'(ex_valid), 64'(m_valid));
         chk("rand ex_word", 64'(ex_word), 64'(m_word));
         chk("rand stall_cnt", 64'(stall_cnt), 64'(m_stall));
         chk("rand flush_cnt", 64'(flush_cnt), 64'(m_flush));
         if (rr) got_ready = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
